// File: rtl/jcr_intc.sv
// jcr_intc - interrupt controller for the jacaranda-8 core.
//
// Up to NSRC peripheral lines share the core's single interrupt input.
// Rising edges are latched into PEND. The lowest-index bit of (PEND & MASK)
// wins and is issued as a one-cycle int_req with a vector address. No new
// request is issued until int_ret reports the handler's return.
//
// Optional build macro: JCR_INTC_SYNC_EN
//   defined   - each irq_src bit passes through a 2-flop synchronizer before
//               edge detection (adds 2 cycles of latency)
//   undefined - irq_src must already be synchronous to clock
//
// Ports:
//   clock, reset       system clock; asynchronous active-high reset
//   irq_src[NSRC]      peripheral interrupt lines, rising edge requests service
//   int_ret            one-cycle pulse when the core executes ret
//   reg_we/addr/wdata  register write port
//   reg_rdata          combinational read data for reg_addr
//                        0 MASK, 1 PEND (W1C), 2 CTRL/STAT, 3 VEC_BASE
//   int_req            registered one-cycle request pulse
//   int_vec            registered handler address
//   int_en             bit0 = GIE, other bits 0
module jcr_intc #(
    parameter int         NSRC            = 8,
    parameter int         VEC_STRIDE_LOG2 = 2,
    parameter logic [7:0] VEC_BASE_RST    = 8'h80
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            int_ret,
    input  logic            reg_we,
    input  logic [1:0]      reg_addr,
    input  logic [7:0]      reg_wdata,
    output logic [7:0]      reg_rdata,
    output logic            int_req,
    output logic [7:0]      int_vec,
    output logic [7:0]      int_en
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state, state_d;
    logic [NSRC-1:0] src_s, prev, rise;
    logic [NSRC-1:0] pend, pend_d, mask, hit, win_oh;
    logic [NSRC-1:0] act_oh, act_oh_d;
    logic [2:0]      act_idx, act_idx_d, win;
    logic [7:0]      vec_base, vec_d;
    logic            gie, req_d;
    logic            wr_mask, wr_pend, wr_ctrl, wr_vbase;
    logic [7:0]      mask8, pend8;

`ifdef JCR_INTC_SYNC_EN
    logic [NSRC-1:0] sync1, sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = irq_src;
`endif

    assign rise     = src_s & ~prev;
    assign hit      = pend & mask;
    // isolate the lowest set bit: the fixed-priority winner as a one-hot
    assign win_oh   = hit & (~hit + 1'b1);

    assign wr_mask  = reg_we && (reg_addr == 2'd0);
    assign wr_pend  = reg_we && (reg_addr == 2'd1);
    assign wr_ctrl  = reg_we && (reg_addr == 2'd2);
    assign wr_vbase = reg_we && (reg_addr == 2'd3);

    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (hit[i]) win = 3'(i);
    end

    always_comb begin
        state_d   = state;
        pend_d    = pend;
        req_d     = 1'b0;
        vec_d     = int_vec;
        act_idx_d = act_idx;
        act_oh_d  = act_oh;

        if (wr_pend) pend_d = pend_d & ~reg_wdata[NSRC-1:0];

        case (state)
            IDLE: begin
                if (gie && (|hit)) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    vec_d     = vec_base + (8'(win) << VEC_STRIDE_LOG2);
                    act_idx_d = win;
                    act_oh_d  = win_oh;
                    pend_d    = pend_d & ~win_oh;
                end
            end
            REQ: begin
                // GIE dropped while the request is on the wire: the core will
                // not take it, so hand the source back to PEND.
                if (wr_ctrl && !reg_wdata[0]) begin
                    state_d = IDLE;
                    pend_d  = pend_d | act_oh;
                end else begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (int_ret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a fresh edge always wins over any clear in the same cycle
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prev     <= '0;
            pend     <= '0;
            mask     <= '0;
            gie      <= 1'b0;
            vec_base <= VEC_BASE_RST;
            int_req  <= 1'b0;
            int_vec  <= 8'h00;
            act_idx  <= '0;
            act_oh   <= '0;
        end else begin
            state    <= state_d;
            prev     <= src_s;
            pend     <= pend_d;
            int_req  <= req_d;
            int_vec  <= vec_d;
            act_idx  <= act_idx_d;
            act_oh   <= act_oh_d;
            if (wr_mask)  mask     <= reg_wdata[NSRC-1:0];
            if (wr_ctrl)  gie      <= reg_wdata[0];
            if (wr_vbase) vec_base <= reg_wdata;
        end
    end

    always_comb begin
        mask8 = '0;
        pend8 = '0;
        for (int i = 0; i < NSRC; i++) begin
            mask8[i] = mask[i];
            pend8[i] = pend[i];
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            2'd0: reg_rdata = mask8;
            2'd1: reg_rdata = pend8;
            2'd2: reg_rdata = {state == SERVICE, act_idx, 3'b000, gie};
            2'd3: reg_rdata = vec_base;
            default: reg_rdata = 8'h00;
        endcase
    end

    assign int_en = {7'b0, gie};

endmodule
